// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg: shared definitions for the product accumulator.
//   - st_t               : FSM state encoding (ACC, HOLD)
//   - DEF_PROD_W/ACC_W/COUNT : default parameter values
//   - sat_max / sat_min  : signed saturation limits for a given width
package prod_acc_pkg;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } st_t;

   localparam int DEF_PROD_W = 16;
   localparam int DEF_ACC_W  = 20;
   localparam int DEF_COUNT  = 8;

   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/prod_accumulator_if.sv
// prod_accumulator_if: product input and result output handshakes.
//   in_valid/in_ready/prod           : product stream from the multiplier
//   out_valid/out_ready/acc_out/out_ovf : finished dot-product result
// Modports: master = producer/consumer side, slave = accumulator.
interface prod_accumulator_if
   import prod_acc_pkg::*;
#(
   parameter int PROD_W = DEF_PROD_W,
   parameter int ACC_W  = DEF_ACC_W
);
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] prod;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  acc_out;
   logic              out_ovf;

   modport master (
      output in_valid, prod, out_ready,
      input  in_ready, out_valid, acc_out, out_ovf
   );

   modport slave (
      input  in_valid, prod, out_ready,
      output in_ready, out_valid, acc_out, out_ovf
   );
endinterface

// File: rtl/prod_accumulator_sat_add.sv
// sat_add: combinational signed add of an ACC_W accumulator and a PROD_W
// product, with overflow detect.
//   a      in  ACC_W   signed accumulator value
//   b      in  PROD_W  signed product (sign-extended internally)
//   result out ACC_W   wrapped sum, or clamped sum when
//                      PROD_ACC_SATURATE_EN is defined
//   ovf    out 1       sum does not fit in ACC_W bits
module sat_add
   import prod_acc_pkg::*;
#(
   parameter int PROD_W = DEF_PROD_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic [ACC_W-1:0]  a,
   input  logic [PROD_W-1:0] b,
   output logic [ACC_W-1:0]  result,
   output logic              ovf
);
`ifdef PROD_ACC_SATURATE_EN
   localparam logic [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(ACC_W));
   localparam logic [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(ACC_W));
`endif

   logic [ACC_W:0] sum;

   always_comb begin
      // One guard bit: the two top bits disagree exactly when the true
      // result lies outside the ACC_W signed range.
      sum = (ACC_W+1)'($signed(a)) + (ACC_W+1)'($signed(b));
      ovf = sum[ACC_W] ^ sum[ACC_W-1];
`ifdef PROD_ACC_SATURATE_EN
      if (ovf) result = sum[ACC_W] ? SAT_LO : SAT_HI;
      else     result = sum[ACC_W-1:0];
`else
      result = sum[ACC_W-1:0];
`endif
   end
endmodule

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums COUNT consecutive signed products into an ACC_W
// accumulator and presents each sum on a valid/ready result port. Input is
// stalled while a result is held.
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   clr  in  synchronous clear of the partial sum (ignored while holding)
//   bus  slave modport of prod_accumulator_if (product in, result out)
// Optional build macro PROD_ACC_SATURATE_EN: clamp on overflow instead of wrap.
//
//   state | meaning
//   ------+-------------------------------------------------
//   ACC   | accepting products, building the partial sum
//   HOLD  | result held on acc_out until out_ready
module prod_accumulator
   import prod_acc_pkg::*;
#(
   parameter int PROD_W = DEF_PROD_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int COUNT  = DEF_COUNT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   prod_accumulator_if.slave bus
);
   localparam int               CNT_W = $clog2(COUNT) + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(COUNT - 1);

   st_t              state, state_d;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf_sticky;
   logic             out_valid_q;
   logic [ACC_W-1:0] acc_out_q;
   logic             out_ovf_q;

   logic             in_ready;
   logic             accept;
   logic             last;
   logic [ACC_W-1:0] add_res;
   logic             add_ovf;

   sat_add #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
      .a      (acc),
      .b      (bus.prod),
      .result (add_res),
      .ovf    (add_ovf)
   );

   always_comb begin
      in_ready = (state == ACC) && !clr;
      accept   = bus.in_valid && in_ready;
      last     = (cnt == LAST);
   end

   always_comb begin
      state_d = state;
      case (state)
         ACC:  if (accept && last)                 state_d = HOLD;
         HOLD: if (out_valid_q && bus.out_ready)   state_d = ACC;
         default:                                  state_d = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ACC;
      else     state <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         cnt         <= '0;
         ovf_sticky  <= 1'b0;
         out_valid_q <= 1'b0;
         acc_out_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else if (state == ACC) begin
         if (clr) begin
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
         end else if (accept) begin
            if (last) begin
               acc_out_q   <= add_res;
               out_ovf_q   <= ovf_sticky | add_ovf;
               out_valid_q <= 1'b1;
               acc         <= '0;
               cnt         <= '0;
               ovf_sticky  <= 1'b0;
            end else begin
               acc        <= add_res;
               cnt        <= cnt + 1'b1;
               ovf_sticky <= ovf_sticky | add_ovf;
            end
         end
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.acc_out   = acc_out_q;
   assign bus.out_ovf   = out_ovf_q;
endmodule
